// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and FSM state type for the MAC operand feeder
package mac_pkg;

    localparam int MAC_DATA_WIDTH = 8;
    localparam int MAC_DEPTH      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head read and overflow/underflow guards
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - buffers A/B operand vectors and streams them into a clear/enable MAC
module mac_feeder
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = MAC_DATA_WIDTH,
    parameter int DEPTH      = MAC_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_wr_en,
    input  logic [DATA_WIDTH-1:0] a_wr_data,
    input  logic                  b_wr_en,
    input  logic [DATA_WIDTH-1:0] b_wr_data,
    input  logic                  start,
    output logic                  a_full,
    output logic                  b_full,
    output logic                  busy,
    output logic                  done,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b
);

    localparam int CW = $clog2(DEPTH);

    feeder_state_t         state;
    logic [CW-1:0]         elem_cnt;
    logic [DATA_WIDTH-1:0] a_head;
    logic [DATA_WIDTH-1:0] b_head;
    logic                  a_empty;
    logic                  b_empty;
    logic                  in_idle;
    logic                  in_stream;

    assign in_idle   = (state == ST_IDLE);
    assign in_stream = (state == ST_STREAM);

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_a_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (a_wr_en && in_idle),
        .wr_data (a_wr_data),
        .rd_en   (in_stream && !a_empty),
        .rd_data (a_head),
        .full    (a_full),
        .empty   (a_empty)
    );

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_b_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (b_wr_en && in_idle),
        .wr_data (b_wr_data),
        .rd_en   (in_stream && !b_empty),
        .rd_data (b_head),
        .full    (b_full),
        .empty   (b_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            elem_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    elem_cnt <= '0;
                    if (start && a_full && b_full) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    // Compare against DEPTH-1 so the counter never needs to represent DEPTH.
                    if (elem_cnt == CW'(DEPTH - 1)) begin
                        elem_cnt <= '0;
                        state    <= ST_DONE;
                    end else begin
                        elem_cnt <= elem_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = !in_idle;
    assign mac_clr = (state == ST_CLEAR);
    assign mac_en  = in_stream;
    assign done    = (state == ST_DONE);
    assign mac_a   = in_stream ? a_head : '0;
    assign mac_b   = in_stream ? b_head : '0;

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width matching the downstream MAC.
REQ-002 SHALL have parameter DEPTH, default 8, vector length and per-operand buffer depth (power of two, >=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 a_wr_en  input  1  push a_wr_data into A buffer.
REQ-006 a_wr_data  input  DATA_WIDTH  A operand element.
REQ-007 b_wr_en  input  1  push b_wr_data into B buffer.
REQ-008 b_wr_data  input  DATA_WIDTH  B operand element.
REQ-009 start  input  1  request one dot-product run.
REQ-010 a_full / b_full  output  1 each  buffer holds DEPTH entries.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse; MAC result valid on downstream Cout this cycle.
REQ-013 mac_clr  output  1  drives MAC Clr.
REQ-014 mac_en  output  1  drives MAC En.
REQ-015 mac_a / mac_b  output  DATA_WIDTH each  drive MAC Ain/Bin.

Function
REQ-016 Buffers SHALL be FIFO order; a write SHALL be accepted only in IDLE with the target buffer not full; other writes SHALL be dropped with no state change.
REQ-017 A and B writes in the same cycle SHALL be independent.
REQ-018 FSM states SHALL be IDLE, CLEAR, STREAM, DONE.
REQ-019 IDLE->CLEAR SHALL occur on start while a_full and b_full are both high; start otherwise SHALL be ignored, including in any non-IDLE state.
REQ-020 CLEAR SHALL last exactly one cycle with mac_clr=1, mac_en=0, then go to STREAM.
REQ-021 STREAM SHALL last exactly DEPTH cycles with mac_en=1, mac_clr=0, popping one entry from each buffer per cycle.
REQ-022 During STREAM mac_a/mac_b SHALL equal the current A/B buffer heads, so element k is presented in STREAM cycle k (k=0..DEPTH-1).
REQ-023 An element counter of width $clog2(DEPTH) SHALL index STREAM and SHALL exit to DONE when it reaches DEPTH-1, with no wrap artefacts.
REQ-024 DONE SHALL last one cycle with done=1, mac_en=0, mac_clr=0, then return to IDLE; both buffers SHALL be empty on return.
REQ-025 Outside STREAM mac_a and mac_b SHALL be 0.
REQ-026 Latency: start accepted in cycle t -> mac_clr at t+1, mac_en t+2..t+DEPTH+1, done at t+DEPTH+2.
REQ-027 Back-to-back runs SHALL be supported: refill in IDLE, next start accepted; total cycles per run excluding fill = DEPTH+3.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, both buffers empty, counter=0.
REQ-029 While in reset and the cycle after: busy=0, done=0, mac_en=0, mac_clr=0, mac_a=mac_b=0, a_full=b_full=0.
REQ-030 Reset mid-STREAM SHALL abort the run with no done pulse and discard all buffered data.
REQ-031 rst SHALL take priority over start and writes in the same cycle.

Structure
REQ-032 Package mac_pkg SHALL hold the FSM state enum and default DATA_WIDTH/DEPTH constants.
REQ-033 One sub-module sync_fifo (parameters WIDTH, DEPTH; wr_en, wr_data, rd_en, rd_data, full, empty; synchronous active-high rst) SHALL be instantiated twice, for A and B.
REQ-034 mac_en, mac_clr, busy and done SHALL be decoded from the registered state only.

Verification
REQ-035 Fill A=1..8, B=2 each, start, MAC attached -> mac_clr one cycle, mac_en 8 cycles, done at t+10, Cout=72.
REQ-036 Fill A=B=255 x8, start -> Cout=520200 at done, no overflow in 24-bit Cout.
REQ-037 Fill A x8, B x7, pulse start -> ignored: busy stays 0, no mac_en; 8th B write then start -> run proceeds.
REQ-038 Write 9th element to full A in IDLE, and writes during STREAM -> dropped; run uses original 8 values, buffers empty after done.
REQ-039 Two consecutive runs (1..8 x 1, then 1..8 x 3) -> Cout 36 then 108; mac_clr clears between runs.
REQ-040 Assert rst in STREAM cycle 4 -> next cycle busy=0, mac_en=0, a_full=b_full=0, no done pulse.
